str_ring_monitor: RTL

- Clocked readout for the 30-stage self-timed NOR/INV ring; it observes the ring from the synchronous domain.
- Ring stage outputs arrive asynchronously and are synchronized. The block counts transitions of one selected stage over a programmable window of clk cycles and reports the token count of the ring at window end.
- The results feed characterisation logic: frequency estimate and token/bubble occupancy check.

---
 rtl/str_ring_monitor.sv | 109 ++++++++++
 1 files changed

// File: rtl/str_ring_monitor.sv
// Synchronous readout for a self-timed NOR/INV ring. It measures edges on one
// selected stage over a clk-cycle window and snapshots the ring token count.
module str_ring_monitor #(
   parameter int N_STAGES = 30,
   parameter int CNT_W    = 16,
   parameter int WIN_W    = 16,
   parameter int SEL_W    = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_STAGES-1:0] ring_q,
   input  logic                start,
   input  logic [WIN_W-1:0]    window_len,
   input  logic [SEL_W-1:0]    tap_sel,
   output logic                busy,
   output logic                done,
   output logic [CNT_W-1:0]    edge_count,
   output logic [SEL_W:0]      token_count,
   output logic                overflow
);

   localparam int TOK_W = SEL_W + 1;

   typedef enum logic [1:0] {IDLE, ARM, COUNT, REPORT} state_t;

   state_t              state, state_nx;
   logic [N_STAGES-1:0] s_meta, s;
   logic                tap_d;
   logic [SEL_W-1:0]    tap_r;
   logic [WIN_W-1:0]    win_len_r, win_cnt;
   logic                tap_now, edge_hit, last_cycle;
   logic [TOK_W-1:0]    token_nx;

   assign tap_now    = s[tap_r];
   assign edge_hit   = tap_now ^ tap_d;
   assign last_cycle = (win_cnt == win_len_r - 1'b1);

   // Tokens sit wherever neighbouring stages disagree, including the wrap pair.
   always_comb begin
      token_nx = '0;
      for (int i = 0; i < N_STAGES; i++) begin
         token_nx = token_nx + TOK_W'(s[i] ^ s[(i + 1) % N_STAGES]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      busy     = (state != IDLE);
      done     = 1'b0;
      case (state)
         IDLE:    if (start) state_nx = ARM;
         ARM:     state_nx = (win_len_r == '0) ? REPORT : COUNT;
         COUNT:   if (last_cycle) state_nx = REPORT;
         REPORT: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Only s_meta ever sees raw ring_q; tap_d always trails the selected tap by one
   // cycle, so the ARM cycle primes it and the first COUNT cycle sees no false edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_meta      <= '0;
         s           <= '0;
         tap_d       <= 1'b0;
         tap_r       <= '0;
         win_len_r   <= '0;
         win_cnt     <= '0;
         edge_count  <= '0;
         token_count <= '0;
         overflow    <= 1'b0;
      end else begin
         s_meta <= ring_q;
         s      <= s_meta;
         tap_d  <= tap_now;
         case (state)
            IDLE: begin
               if (start) begin
                  win_len_r <= window_len;
                  tap_r     <= (32'(tap_sel) < N_STAGES) ? tap_sel : '0;
               end
            end
            ARM: begin
               edge_count <= '0;
               overflow   <= 1'b0;
               win_cnt    <= '0;
            end
            COUNT: begin
               win_cnt <= win_cnt + 1'b1;
               if (edge_hit) begin
                  if (edge_count == '1) overflow   <= 1'b1;
                  else                  edge_count <= edge_count + 1'b1;
               end
               if (last_cycle) token_count <= token_nx;
            end
            default: ;
         endcase
      end
   end

endmodule
